// File: rtl/obstacle_lanes_pkg.sv
// Shared constants, lane state record and x-wrap helpers for the obstacle lane stage.
package obstacle_lanes_pkg;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int NUM_LANES = 8;
  localparam int LANE_H    = 60;
  localparam int CAR_W     = 48;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;

  typedef struct packed {
    logic       active;
    logic       dir;
    logic [1:0] speed;
    logic [9:0] car_x;
  } lane_t;

  // Single conditional subtract; callers guarantee x < 2*SCREEN_W.
  function automatic logic [9:0] wrap_x(input logic [10:0] x);
    return (x >= 11'(SCREEN_W)) ? 10'(x - 11'(SCREEN_W)) : x[9:0];
  endfunction

  function automatic logic [9:0] step_car(input lane_t l);
    if (!l.dir)
      return wrap_x({1'b0, l.car_x} + {9'd0, l.speed});
    else if (l.car_x < {8'd0, l.speed})
      return 10'({1'b0, l.car_x} + 11'(SCREEN_W) - {9'd0, l.speed});
    else
      return l.car_x - {8'd0, l.speed};
  endfunction
endpackage

// File: rtl/obstacle_lanes_if.sv
// Scroll/beam inputs and pixel/collision outputs of the obstacle lane stage.
interface obstacle_lanes_if;
  logic [9:0] y_pos;
  logic       move_followers;
  logic       frame_start;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic [9:0] player_x;
  logic       obstacle_px;
  logic       collision;

  modport master (
    output y_pos, move_followers, frame_start, hpos, vpos, display_on, player_x,
    input  obstacle_px, collision
  );

  modport slave (
    input  y_pos, move_followers, frame_start, hpos, vpos, display_on, player_x,
    output obstacle_px, collision
  );
endinterface

// File: rtl/obstacle_lanes_lfsr.sv
// Free-running 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), right-shifting.
module lane_lfsr
  import obstacle_lanes_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_RESET
)(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] o_lfsr
);
  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= SEED;
    else
      r_state <= {1'b0, r_state[15:1]} ^ (r_state[0] ? LFSR_TAPS : 16'h0000);
  end

  assign o_lfsr = r_state;
endmodule

// File: rtl/obstacle_lanes.sv
// World-space traffic lanes: per-frame car motion, LFSR lane regeneration as lanes
// scroll in at the top, one-cycle obstacle pixel render and sticky player collision.
module obstacle_lanes
  import obstacle_lanes_pkg::*;
#(
  parameter int          PLAYER_Y  = 440,
  parameter int          PLAYER_SZ = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_RESET
)(
  input logic             clk,
  input logic             reset,
  obstacle_lanes_if.slave bus
);
  localparam int LIDX_W = $clog2(NUM_LANES);

  logic [15:0] w_lfsr;
  logic        w_unused;

  lane_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  assign w_unused = &{1'b0, w_lfsr[15:14]};

  lane_t r_lane [NUM_LANES];
  logic  r_px, r_hit, r_coll;

  // Screen row -> world row -> lane, using subtract/compare chains instead of a divider.
  logic [10:0]       w_diff;
  logic [8:0]        w_world;
  logic [LIDX_W-1:0] w_lane_idx;

  always_comb begin
    w_diff = {1'b0, bus.vpos} + 11'(SCREEN_H) - {1'b0, bus.y_pos};
    if (w_diff >= 11'(3*SCREEN_H))      w_world = 9'(w_diff - 11'(3*SCREEN_H));
    else if (w_diff >= 11'(2*SCREEN_H)) w_world = 9'(w_diff - 11'(2*SCREEN_H));
    else if (w_diff >= 11'(SCREEN_H))   w_world = 9'(w_diff - 11'(SCREEN_H));
    else                                w_world = 9'(w_diff);
    w_lane_idx = '0;
    for (int k = 1; k < NUM_LANES; k++)
      if (w_world >= 9'(k*LANE_H)) w_lane_idx = LIDX_W'(k);
  end

  lane_t       w_sel;
  logic [10:0] w_dx_raw;
  logic [9:0]  w_dx;
  logic        w_car_px;
  logic        w_player_hit;

  always_comb begin
    w_sel    = r_lane[w_lane_idx];
    w_dx_raw = {1'b0, bus.hpos} + 11'(SCREEN_W) - {1'b0, w_sel.car_x};
    if (w_dx_raw >= 11'(2*SCREEN_W))  w_dx = 10'(w_dx_raw - 11'(2*SCREEN_W));
    else if (w_dx_raw >= 11'(SCREEN_W)) w_dx = 10'(w_dx_raw - 11'(SCREEN_W));
    else                                w_dx = 10'(w_dx_raw);
    w_car_px = bus.display_on & w_sel.active & (w_dx < 10'(CAR_W));
    w_player_hit = (bus.vpos >= 10'(PLAYER_Y)) &&
                   (bus.vpos <  10'(PLAYER_Y + PLAYER_SZ)) &&
                   ({1'b0, bus.hpos} >= {1'b0, bus.player_x}) &&
                   ({1'b0, bus.hpos} <  {1'b0, bus.player_x} + 11'(PLAYER_SZ));
  end

  // The lane that has just scrolled onto the top row gets fresh contents.
  logic              w_regen;
  logic [LIDX_W-1:0] w_regen_lane;
  lane_t             w_fresh;

  always_comb begin
    w_regen      = 1'b0;
    w_regen_lane = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.y_pos == 10'(k*LANE_H)) begin
        w_regen      = bus.move_followers;
        w_regen_lane = LIDX_W'((NUM_LANES - k) % NUM_LANES);
      end
    end
    w_fresh.active = w_lfsr[0];
    w_fresh.dir    = w_lfsr[1];
    w_fresh.speed  = (w_lfsr[3:2] == 2'd0) ? 2'd1 : w_lfsr[3:2];
    w_fresh.car_x  = wrap_x({1'b0, w_lfsr[13:4]});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_lane[i].active <= ((i % 2) == 0);
        r_lane[i].dir    <= (((i / 2) % 2) == 1);
        r_lane[i].speed  <= 2'd1;
        r_lane[i].car_x  <= 10'(i*80);
      end
      r_px   <= 1'b0;
      r_hit  <= 1'b0;
      r_coll <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_regen && (w_regen_lane == LIDX_W'(i)))
          r_lane[i] <= w_fresh;
        else if (bus.frame_start && r_lane[i].active)
          r_lane[i].car_x <= step_car(r_lane[i]);
      end
      r_px   <= w_car_px;
      r_hit  <= w_player_hit;
      r_coll <= r_coll | (r_px & r_hit);
    end
  end

  assign bus.obstacle_px = r_px;
  assign bus.collision   = r_coll;
endmodule
